// File: rtl/seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// seg_disp_ctrl : display sequencer (result latch, peak fetch, key/auto step)
// Rev 1.0
// ============================================================================
module seg_disp_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int DEBOUNCE_CYC = 999_999,
  parameter int AUTO_DUR     = 49_999_999,
  parameter int MAX_PEAKS    = 8,
  parameter int FETCH_TMO    = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        detect_start,
  input  logic        detect_done,
  input  logic [12:0] detect_time_in,
  input  logic [3:0]  peak_count,
  input  logic        key_mode,
  input  logic        key_next,
  input  logic        auto_en,
  output logic        pk_rd_req,
  output logic [2:0]  pk_rd_idx,
  input  logic        pk_rd_valid,
  input  logic [4:0]  pk_rd_row,
  input  logic [4:0]  pk_rd_col,
  input  logic [7:0]  pk_rd_val,
  output logic [1:0]  disp_mode,
  output logic [12:0] detect_time,
  output logic [2:0]  disp_peak_idx,
  output logic [4:0]  disp_peak_row,
  output logic [4:0]  disp_peak_col,
  output logic [7:0]  disp_peak_val
);

  localparam int DB_W = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int AT_W = (AUTO_DUR > 0) ? $clog2(AUTO_DUR + 1) : 1;
  localparam int TO_W = $clog2(FETCH_TMO + 1);

  localparam logic [1:0] MODE_TIME = 2'b01;
  localparam logic [1:0] MODE_RC   = 2'b10;
  localparam logic [1:0] MODE_VAL  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_SHOW = 2'd2} state_t;

  if (CLK_FREQ <= 0 || MAX_PEAKS < 1 || MAX_PEAKS > 8 || FETCH_TMO < 1) begin : g_bad_param
    $error("seg_disp_ctrl: illegal parameter set");
  end

  // press[0] = mode key, press[1] = next key
  logic [1:0] keys_raw;
  logic [1:0] press;
  assign keys_raw = {key_next, key_mode};

  for (genvar i = 0; i < 2; i++) begin : g_key
    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_cnt;
    logic            r_fired;
    logic            r_pulse;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_sync  <= 2'b11;
        r_cnt   <= '0;
        r_fired <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], keys_raw[i]};
        r_pulse <= 1'b0;
        if (r_sync[1]) begin
          r_cnt   <= '0;
          r_fired <= 1'b0;
        end else if (!r_fired) begin
          if (r_cnt == DB_W'(DEBOUNCE_CYC)) begin
            r_pulse <= 1'b1;
            r_fired <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
    assign press[i] = r_pulse;
  end

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [1:0]      r_next_mode;
  logic [TO_W-1:0] r_tmo;
  logic [AT_W-1:0] r_auto_cnt;

  logic       w_auto_tick;
  logic [3:0] w_cnt_sat;
  logic [2:0] w_next_idx;
  logic       w_show_live;
  logic       w_fetch_go;
  logic [2:0] w_fetch_idx;
  logic [1:0] w_fetch_mode;
  logic [1:0] w_mode_step;

  assign w_auto_tick = auto_en && (r_auto_cnt == AT_W'(AUTO_DUR));
  assign w_cnt_sat   = (peak_count > 4'(MAX_PEAKS)) ? 4'(MAX_PEAKS) : peak_count;
  assign w_next_idx  = ({1'b0, pk_rd_idx} == r_cnt - 4'd1) ? 3'd0 : pk_rd_idx + 3'd1;
  assign w_show_live = (r_state == ST_SHOW) && (r_cnt != 4'd0);

  always_comb begin
    case (disp_mode)
      MODE_TIME: w_mode_step = MODE_RC;
      MODE_RC:   w_mode_step = MODE_VAL;
      default:   w_mode_step = MODE_TIME;
    endcase
  end

  // Decides whether this cycle launches a read; encodes the event priority.
  always_comb begin
    w_fetch_go   = 1'b0;
    w_fetch_idx  = pk_rd_idx;
    w_fetch_mode = disp_mode;
    if (detect_start) begin
      w_fetch_go = 1'b0;
    end else if (detect_done) begin
      if (w_cnt_sat != 4'd0) begin
        w_fetch_go   = 1'b1;
        w_fetch_idx  = 3'd0;
        w_fetch_mode = MODE_TIME;
      end
    end else if (w_show_live) begin
      if (press[1]) begin
        w_fetch_go  = 1'b1;
        w_fetch_idx = w_next_idx;
      end else if (w_auto_tick && disp_mode == MODE_VAL) begin
        w_fetch_go   = 1'b1;
        w_fetch_idx  = w_next_idx;
        w_fetch_mode = MODE_RC;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_auto_cnt <= '0;
    end else if (!auto_en || (|press) || w_fetch_go || w_auto_tick) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_next_mode   <= 2'b00;
      r_tmo         <= '0;
      pk_rd_req     <= 1'b0;
      pk_rd_idx     <= 3'd0;
      disp_mode     <= 2'b00;
      detect_time   <= 13'd0;
      disp_peak_idx <= 3'd0;
      disp_peak_row <= 5'd0;
      disp_peak_col <= 5'd0;
      disp_peak_val <= 8'd0;
    end else begin
      pk_rd_req <= 1'b0;
      if (detect_start) begin
        r_state       <= ST_IDLE;
        disp_mode     <= 2'b00;
        detect_time   <= 13'd0;
        disp_peak_idx <= 3'd0;
        disp_peak_row <= 5'd0;
        disp_peak_col <= 5'd0;
        disp_peak_val <= 8'd0;
      end else begin
        if (detect_done) begin
          detect_time <= detect_time_in;
          r_cnt       <= w_cnt_sat;
        end
        if (w_fetch_go) begin
          r_state     <= ST_FETCH;
          pk_rd_req   <= 1'b1;
          pk_rd_idx   <= w_fetch_idx;
          r_next_mode <= w_fetch_mode;
          r_tmo       <= '0;
        end else if (detect_done) begin
          // empty result set: show time only, peak fields stay blank
          r_state       <= ST_SHOW;
          pk_rd_idx     <= 3'd0;
          disp_mode     <= MODE_TIME;
          disp_peak_idx <= 3'd0;
          disp_peak_row <= 5'd0;
          disp_peak_col <= 5'd0;
          disp_peak_val <= 8'd0;
        end else begin
          case (r_state)
            ST_FETCH: begin
              if (pk_rd_valid || r_tmo == TO_W'(FETCH_TMO - 1)) begin
                r_state       <= ST_SHOW;
                disp_mode     <= r_next_mode;
                disp_peak_idx <= pk_rd_idx;
                disp_peak_row <= pk_rd_valid ? pk_rd_row : 5'd0;
                disp_peak_col <= pk_rd_valid ? pk_rd_col : 5'd0;
                disp_peak_val <= pk_rd_valid ? pk_rd_val : 8'd0;
              end else begin
                r_tmo <= r_tmo + 1'b1;
              end
            end
            ST_SHOW: begin
              if (w_show_live && (w_auto_tick || press[0])) begin
                disp_mode <= w_mode_step;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg_disp_ctrl : scoreboard bench for seg_disp_ctrl
// Rev 1.0
// ============================================================================
module tb_seg_disp_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        detect_start = 1'b0, detect_done = 1'b0;
  logic [12:0] detect_time_in = '0;
  logic [3:0]  peak_count = '0;
  logic        key_mode = 1'b1, key_next = 1'b1, auto_en = 1'b0;
  logic        pk_rd_req;
  logic [2:0]  pk_rd_idx;
  logic        pk_rd_valid = 1'b0;
  logic [4:0]  pk_rd_row = '0, pk_rd_col = '0;
  logic [7:0]  pk_rd_val = '0;
  logic [1:0]  disp_mode;
  logic [12:0] detect_time;
  logic [2:0]  disp_peak_idx;
  logic [4:0]  disp_peak_row, disp_peak_col;
  logic [7:0]  disp_peak_val;

  always #5 clk = ~clk;

  seg_disp_ctrl #(
    .CLK_FREQ(50_000_000), .DEBOUNCE_CYC(3), .AUTO_DUR(9), .MAX_PEAKS(8), .FETCH_TMO(15)
  ) dut (
    .clk(clk), .rstn(rstn), .detect_start(detect_start), .detect_done(detect_done),
    .detect_time_in(detect_time_in), .peak_count(peak_count),
    .key_mode(key_mode), .key_next(key_next), .auto_en(auto_en),
    .pk_rd_req(pk_rd_req), .pk_rd_idx(pk_rd_idx), .pk_rd_valid(pk_rd_valid),
    .pk_rd_row(pk_rd_row), .pk_rd_col(pk_rd_col), .pk_rd_val(pk_rd_val),
    .disp_mode(disp_mode), .detect_time(detect_time), .disp_peak_idx(disp_peak_idx),
    .disp_peak_row(disp_peak_row), .disp_peak_col(disp_peak_col), .disp_peak_val(disp_peak_val)
  );

  typedef logic [35:0] tup_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         lat = 2;
  int         last_req = 0;
  logic       mon_en = 1'b0;
  tup_t       prev = '0;
  tup_t       exp_q[$];
  logic [2:0] req_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic tup_t mk(input logic [1:0] m, input logic [2:0] i, input logic [4:0] r,
                              input logic [4:0] c, input logic [7:0] v, input logic [12:0] t);
    return {m, i, r, c, v, t};
  endfunction

  function automatic tup_t cur();
    return {disp_mode, disp_peak_idx, disp_peak_row, disp_peak_col, disp_peak_val, detect_time};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every read request and every change of the displayed tuple is scored.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (pk_rd_req) begin
        last_req = cyc;
        if (req_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_unexpected: got idx=%0d expected no request", pk_rd_idx);
        end else begin
          chk("req_idx", 64'(pk_rd_idx), 64'(req_q.pop_front()));
        end
      end
      if (cur() !== prev) begin
        prev = cur();
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL disp_unexpected: got=%0h expected no change", prev);
        end else begin
          chk("disp_tuple", 64'(prev), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // Peak table model: row = 3*idx+1, col = idx+10, val = A0+idx; lat==0 withholds data.
  initial forever begin
    logic [2:0] ri;
    @(negedge clk);
    if (pk_rd_req && rstn && lat > 0) begin
      ri = pk_rd_idx;
      repeat (lat - 1) @(negedge clk);
      pk_rd_valid = 1'b1;
      pk_rd_row   = {2'b00, ri} * 5'd3 + 5'd1;
      pk_rd_col   = {2'b00, ri} + 5'd10;
      pk_rd_val   = 8'hA0 + {5'd0, ri};
      @(negedge clk);
      pk_rd_valid = 1'b0;
      pk_rd_row   = '0; pk_rd_col = '0; pk_rd_val = '0;
    end
  end

  task automatic press(input int which);
    if (which == 0) key_mode = 1'b0; else key_next = 1'b0;
    repeat (8) @(negedge clk);
    key_mode = 1'b1; key_next = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic glitch(input int which);
    if (which == 0) key_mode = 1'b0; else key_next = 1'b0;
    @(negedge clk);
    key_mode = 1'b1; key_next = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         seq [3] = '{1, 2, 0};
    logic [4:0] rows[3] = '{5'd1, 5'd4, 5'd7};
    logic [4:0] cols[3] = '{5'd10, 5'd11, 5'd12};
    logic [7:0] vals[3] = '{8'hA0, 8'hA1, 8'hA2};
    int t0, t1, t2;

    repeat (3) @(negedge clk);
    chk("reset_disp", 64'(cur()), 64'd0);
    chk("reset_req", 64'(pk_rd_req), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    prev = '0;
    mon_en = 1'b1;

    // detect_done, table answers after 2 cycles
    lat = 2;
    req_q.push_back(3'd0);
    exp_q.push_back(mk(2'd0, 3'd0, 5'd0, 5'd0, 8'd0, 13'd1234));
    exp_q.push_back(mk(2'd1, 3'd0, 5'd1, 5'd10, 8'hA0, 13'd1234));
    detect_time_in = 13'd1234; peak_count = 4'd3; detect_done = 1'b1;
    @(negedge clk);
    detect_done = 1'b0;
    repeat (20) @(negedge clk);

    // mode key with bounce glitches in between
    exp_q.push_back(mk(2'd2, 3'd0, 5'd1, 5'd10, 8'hA0, 13'd1234));
    exp_q.push_back(mk(2'd3, 3'd0, 5'd1, 5'd10, 8'hA0, 13'd1234));
    exp_q.push_back(mk(2'd1, 3'd0, 5'd1, 5'd10, 8'hA0, 13'd1234));
    press(0); glitch(0); press(0); glitch(0); press(0);

    // next key walks 1, 2, wraps to 0; mode stays 01
    for (int k = 0; k < 3; k++) begin
      req_q.push_back(3'(seq[k]));
      exp_q.push_back(mk(2'd1, 3'(seq[k]), rows[seq[k]], cols[seq[k]], vals[seq[k]], 13'd1234));
      press(1);
      glitch(1);
    end

    // reach mode 10 / idx 2, then auto-step
    exp_q.push_back(mk(2'd2, 3'd0, 5'd1, 5'd10, 8'hA0, 13'd1234));
    press(0);
    req_q.push_back(3'd1);
    exp_q.push_back(mk(2'd2, 3'd1, 5'd4, 5'd11, 8'hA1, 13'd1234));
    press(1);
    req_q.push_back(3'd2);
    exp_q.push_back(mk(2'd2, 3'd2, 5'd7, 5'd12, 8'hA2, 13'd1234));
    press(1);
    repeat (4) @(negedge clk);
    exp_q.push_back(mk(2'd3, 3'd2, 5'd7, 5'd12, 8'hA2, 13'd1234));
    req_q.push_back(3'd0);
    exp_q.push_back(mk(2'd2, 3'd0, 5'd1, 5'd10, 8'hA0, 13'd1234));
    t0 = cyc;
    auto_en = 1'b1;
    for (int n = 0; n < 40 && disp_mode != 2'd3; n++) @(negedge clk);
    t1 = cyc;
    chk("auto_tick_to_mode11", 64'(t1 - t0), 64'd10);
    for (int n = 0; n < 40 && !pk_rd_req; n++) @(negedge clk);
    t2 = cyc;
    auto_en = 1'b0;
    chk("auto_tick_to_fetch", 64'(t2 - t1), 64'd10);
    repeat (6) @(negedge clk);

    // table withholds data: timeout after 15 cycles shows zeros
    lat = 0;
    req_q.push_back(3'd1);
    exp_q.push_back(mk(2'd2, 3'd1, 5'd0, 5'd0, 8'd0, 13'd1234));
    press(1);
    for (int n = 0; n < 40 && disp_peak_idx != 3'd1; n++) @(negedge clk);
    chk("fetch_timeout_cycles", 64'(cyc - last_req), 64'd15);
    repeat (2) @(negedge clk);

    // reset in the middle of a fetch
    req_q.push_back(3'd2);
    exp_q.push_back(mk(2'd0, 3'd0, 5'd0, 5'd0, 8'd0, 13'd0));
    press(1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_disp", 64'(cur()), 64'd0);
    chk("async_reset_req", 64'(pk_rd_req), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // zero peaks: mode 01, no reads, keys and auto ignored
    lat = 2;
    exp_q.push_back(mk(2'd1, 3'd0, 5'd0, 5'd0, 8'd0, 13'd55));
    detect_time_in = 13'd55; peak_count = 4'd0; detect_done = 1'b1;
    @(negedge clk);
    detect_done = 1'b0;
    repeat (3) @(negedge clk);
    press(0); press(1);
    auto_en = 1'b1;
    repeat (25) @(negedge clk);
    auto_en = 1'b0;
    chk("zero_cnt_mode", 64'(disp_mode), 64'd1);

    // detect_start clears the display
    exp_q.push_back(mk(2'd0, 3'd0, 5'd0, 5'd0, 8'd0, 13'd0));
    detect_start = 1'b1;
    @(negedge clk);
    detect_start = 1'b0;
    repeat (10) @(negedge clk);

    chk("disp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
